// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared types for the control pipeline registers: stage control slices, bubble constants,
// forwarding select codes and the register-match helper used by the hazard logic.
package ctrl_pipe_regs_pkg;

    localparam int CTRL_W = 17;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        BRU_NOP  = 3'd0,
        BRU_BEQ  = 3'd1,
        BRU_BNE  = 3'd2,
        BRU_BLT  = 3'd3,
        BRU_BGE  = 3'd4,
        BRU_BLTU = 3'd5,
        BRU_BGEU = 3'd6,
        BRU_JAL  = 3'd7
    } bru_op_e;

    typedef struct packed {
        logic       jalr;
        bru_op_e    bruOp;
        logic [3:0] aluOp;
        logic [1:0] aluSrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic [2:0] memOp;
        logic       memWr;
        logic       memRd;
    } mem_ctrl_t;

    typedef struct packed {
        logic regWr;
        logic memToReg;
    } wb_ctrl_t;

    // Full decoder bus; field order matches the bit layout of id_ctrl
    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } mem_stage_t;

    localparam ctrl_t      CTRL_NOP = '0;
    localparam mem_stage_t MEM_NOP  = '0;
    localparam wb_ctrl_t   WB_NOP   = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic readsReg(input logic en,
                                      input logic [REG_AW-1:0] rs,
                                      input logic [REG_AW-1:0] rd);
        return en && (rs == rd) && (rd != '0);
    endfunction

endpackage

// File: rtl/ctrl_pipe_regs_if.sv
// Decode-side inputs and per-stage outputs of the control pipeline registers.
// The fwd_a/fwd_b selects exist only when CTRL_PIPE_FWD_EN is defined.
interface ctrl_pipe_regs_if #(
    parameter int CTRL_W = ctrl_pipe_regs_pkg::CTRL_W,
    parameter int REG_AW = ctrl_pipe_regs_pkg::REG_AW,
    parameter int CNT_W  = ctrl_pipe_regs_pkg::CNT_W
) ();
    import ctrl_pipe_regs_pkg::*;

    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              mem_stall;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    ex_ctrl_t          ex_ctrl;
    mem_ctrl_t         mem_ctrl;
    wb_ctrl_t          wb_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic [CNT_W-1:0]  ld_use_cnt;
`ifdef CTRL_PIPE_FWD_EN
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
`endif

    modport master (
        output id_valid, id_ctrl, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output mem_stall, flush,
`ifdef CTRL_PIPE_FWD_EN
        input  fwd_a, fwd_b,
`endif
        input  id_stall, ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_rd, mem_rd, wb_rd, ld_use_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  mem_stall, flush,
`ifdef CTRL_PIPE_FWD_EN
        output fwd_a, fwd_b,
`endif
        output id_stall, ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_rd, mem_rd, wb_rd, ld_use_cnt
    );

endinterface

// File: rtl/ctrl_pipe_regs_hazard_unit.sv
// Combinational hazard detection for the decode stage and, with CTRL_PIPE_FWD_EN defined,
// EX operand forwarding selects. Holds no state.
module ctrl_pipe_regs_hazard_unit
    import ctrl_pipe_regs_pkg::*;
(
    input  logic              idValid_i,
    input  logic [REG_AW-1:0] idRs1_i,
    input  logic [REG_AW-1:0] idRs2_i,
    input  logic              idUseRs1_i,
    input  logic              idUseRs2_i,
    input  logic              exValid_i,
    input  logic [REG_AW-1:0] exRd_i,
    input  logic              exMemRd_i,
    input  logic              memValid_i,
    input  logic [REG_AW-1:0] memRd_i,
    input  logic              memRegWr_i,
`ifdef CTRL_PIPE_FWD_EN
    input  logic [REG_AW-1:0] exRs1_i,
    input  logic [REG_AW-1:0] exRs2_i,
    input  logic              wbValid_i,
    input  logic [REG_AW-1:0] wbRd_i,
    input  logic              wbRegWr_i,
    output logic [1:0]        fwdA_o,
    output logic [1:0]        fwdB_o,
`else
    input  logic              exRegWr_i,
`endif
    output logic              hazard_o,
    output logic              loadUse_o
);

    logic idDepEx;

    assign idDepEx   = readsReg(idUseRs1_i, idRs1_i, exRd_i) || readsReg(idUseRs2_i, idRs2_i, exRd_i);
    assign loadUse_o = idValid_i && exValid_i && exMemRd_i && idDepEx;

`ifdef CTRL_PIPE_FWD_EN
    logic memWrites;
    logic wbWrites;

    assign memWrites = memValid_i && memRegWr_i;
    assign wbWrites  = wbValid_i && wbRegWr_i;
    assign hazard_o  = loadUse_o;

    // The younger producer in MEM holds the newer value, so it beats WB
    always_comb begin
        fwdA_o = FWD_RF;
        fwdB_o = FWD_RF;
        if (memWrites && readsReg(1'b1, exRs1_i, memRd_i)) begin
            fwdA_o = FWD_MEM;
        end else if (wbWrites && readsReg(1'b1, exRs1_i, wbRd_i)) begin
            fwdA_o = FWD_WB;
        end
        if (memWrites && readsReg(1'b1, exRs2_i, memRd_i)) begin
            fwdB_o = FWD_MEM;
        end else if (wbWrites && readsReg(1'b1, exRs2_i, wbRd_i)) begin
            fwdB_o = FWD_WB;
        end
    end
`else
    logic idDepMem;

    // Without bypass paths the consumer waits until the producer sits in WB
    assign idDepMem = readsReg(idUseRs1_i, idRs1_i, memRd_i) || readsReg(idUseRs2_i, idRs2_i, memRd_i);
    assign hazard_o = loadUse_o ||
                      (idValid_i && ((exValid_i && exRegWr_i && idDepEx) ||
                                     (memValid_i && memRegWr_i && idDepMem)));
`endif

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control registers with bubble insertion for stalls and flushes.
// Defining CTRL_PIPE_FWD_EN tracks EX source tags and drives forwarding selects.
module ctrl_pipe_regs
    import ctrl_pipe_regs_pkg::*;
#(
    parameter int CTRL_W = ctrl_pipe_regs_pkg::CTRL_W,
    parameter int REG_AW = ctrl_pipe_regs_pkg::REG_AW,
    parameter int CNT_W  = ctrl_pipe_regs_pkg::CNT_W
) (
    input logic             clk,
    input logic             rst,
    ctrl_pipe_regs_if.slave bus
);

    logic [CTRL_W-1:0] idCtrlRaw;
    ctrl_t             idCtrl;
    logic              hazard;
    logic              loadUse;

    logic              exValid_q,  exValid_d;
    ctrl_t             exCtrl_q,   exCtrl_d;
    logic [REG_AW-1:0] exRd_q,     exRd_d;
    logic              memValid_q, memValid_d;
    mem_stage_t        memCtrl_q,  memCtrl_d;
    logic [REG_AW-1:0] memRd_q,    memRd_d;
    logic              wbValid_q,  wbValid_d;
    wb_ctrl_t          wbCtrl_q,   wbCtrl_d;
    logic [REG_AW-1:0] wbRd_q,     wbRd_d;
    logic [CNT_W-1:0]  ldUseCnt_q, ldUseCnt_d;
`ifdef CTRL_PIPE_FWD_EN
    logic [REG_AW-1:0] exRs1_q,    exRs1_d;
    logic [REG_AW-1:0] exRs2_q,    exRs2_d;
`endif

    assign idCtrlRaw = bus.id_ctrl;
    assign idCtrl    = ctrl_t'(idCtrlRaw);

    ctrl_pipe_regs_hazard_unit u_hazard (
        .idValid_i  (bus.id_valid),
        .idRs1_i    (bus.id_rs1),
        .idRs2_i    (bus.id_rs2),
        .idUseRs1_i (bus.id_use_rs1),
        .idUseRs2_i (bus.id_use_rs2),
        .exValid_i  (exValid_q),
        .exRd_i     (exRd_q),
        .exMemRd_i  (exCtrl_q.mem.memRd),
        .memValid_i (memValid_q),
        .memRd_i    (memRd_q),
        .memRegWr_i (memCtrl_q.wb.regWr),
`ifdef CTRL_PIPE_FWD_EN
        .exRs1_i    (exRs1_q),
        .exRs2_i    (exRs2_q),
        .wbValid_i  (wbValid_q),
        .wbRd_i     (wbRd_q),
        .wbRegWr_i  (wbCtrl_q.regWr),
        .fwdA_o     (bus.fwd_a),
        .fwdB_o     (bus.fwd_b),
`else
        .exRegWr_i  (exCtrl_q.wb.regWr),
`endif
        .hazard_o   (hazard),
        .loadUse_o  (loadUse)
    );

    // Memory stall freezes EX/MEM and drains WB so no register write repeats;
    // flush and hazards both turn the incoming ID slot into a bubble
    always_comb begin
        exValid_d  = exValid_q;
        exCtrl_d   = exCtrl_q;
        exRd_d     = exRd_q;
        memValid_d = memValid_q;
        memCtrl_d  = memCtrl_q;
        memRd_d    = memRd_q;
        wbValid_d  = 1'b0;
        wbCtrl_d   = WB_NOP;
        wbRd_d     = '0;
        ldUseCnt_d = ldUseCnt_q;
`ifdef CTRL_PIPE_FWD_EN
        exRs1_d    = exRs1_q;
        exRs2_d    = exRs2_q;
`endif
        if (!bus.mem_stall) begin
            wbValid_d  = memValid_q;
            wbCtrl_d   = memCtrl_q.wb;
            wbRd_d     = memRd_q;
            memValid_d = exValid_q;
            memCtrl_d  = '{mem: exCtrl_q.mem, wb: exCtrl_q.wb};
            memRd_d    = exRd_q;
            if (bus.flush || hazard || !bus.id_valid) begin
                exValid_d = 1'b0;
                exCtrl_d  = CTRL_NOP;
                exRd_d    = '0;
`ifdef CTRL_PIPE_FWD_EN
                exRs1_d   = '0;
                exRs2_d   = '0;
`endif
            end else begin
                exValid_d = 1'b1;
                exCtrl_d  = idCtrl;
                exRd_d    = bus.id_rd;
`ifdef CTRL_PIPE_FWD_EN
                exRs1_d   = bus.id_rs1;
                exRs2_d   = bus.id_rs2;
`endif
            end
            if (!bus.flush && loadUse && (ldUseCnt_q != '1)) begin
                ldUseCnt_d = ldUseCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q  <= 1'b0;
            exCtrl_q   <= CTRL_NOP;
            exRd_q     <= '0;
            memValid_q <= 1'b0;
            memCtrl_q  <= MEM_NOP;
            memRd_q    <= '0;
            wbValid_q  <= 1'b0;
            wbCtrl_q   <= WB_NOP;
            wbRd_q     <= '0;
            ldUseCnt_q <= '0;
`ifdef CTRL_PIPE_FWD_EN
            exRs1_q    <= '0;
            exRs2_q    <= '0;
`endif
        end else begin
            exValid_q  <= exValid_d;
            exCtrl_q   <= exCtrl_d;
            exRd_q     <= exRd_d;
            memValid_q <= memValid_d;
            memCtrl_q  <= memCtrl_d;
            memRd_q    <= memRd_d;
            wbValid_q  <= wbValid_d;
            wbCtrl_q   <= wbCtrl_d;
            wbRd_q     <= wbRd_d;
            ldUseCnt_q <= ldUseCnt_d;
`ifdef CTRL_PIPE_FWD_EN
            exRs1_q    <= exRs1_d;
            exRs2_q    <= exRs2_d;
`endif
        end
    end

    assign bus.id_stall   = !rst && (bus.mem_stall || (!bus.flush && hazard));
    assign bus.ex_valid   = exValid_q;
    assign bus.ex_ctrl    = exCtrl_q.ex;
    assign bus.ex_rd      = exRd_q;
    assign bus.mem_valid  = memValid_q;
    assign bus.mem_ctrl   = memCtrl_q.mem;
    assign bus.mem_rd     = memRd_q;
    assign bus.wb_valid   = wbValid_q;
    assign bus.wb_ctrl    = wbCtrl_q;
    assign bus.wb_rd      = wbRd_q;
    assign bus.ld_use_cnt = ldUseCnt_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed bench for ctrl_pipe_regs; the forwarding checks follow CTRL_PIPE_FWD_EN.
module tb_ctrl_pipe_regs;

    // {jalr,bruOp,aluOp,aluSrc | memOp,memWr,memRd | regWr,memToReg}
    localparam logic [16:0] LW  = 17'b0_000_0000_01_010_0_1_1_1;
    localparam logic [16:0] ADD = 17'b0_000_0000_00_000_0_0_1_0;
    localparam logic [16:0] SUB = 17'b0_000_0001_00_000_0_0_1_0;
    localparam logic [16:0] BNE = 17'b0_010_0001_00_000_0_0_0_0;
    localparam logic [16:0] SW  = 17'b0_000_0000_01_010_1_0_0_0;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ctrl_pipe_regs_if bus ();

    ctrl_pipe_regs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [16:0] ctrl, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2);
        bus.id_valid   = 1'b1;
        bus.id_ctrl    = ctrl;
        bus.id_rd      = rd;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
    endtask

    task automatic idle();
        bus.id_valid   = 1'b0;
        bus.id_ctrl    = '0;
        bus.id_rd      = '0;
        bus.id_rs1     = '0;
        bus.id_rs2     = '0;
        bus.id_use_rs1 = 1'b0;
        bus.id_use_rs2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle();
        vectors++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_valids: got %b expected 000", {bus.ex_valid, bus.mem_valid, bus.wb_valid});
        end
        vectors++;
        if ({bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl} !== 17'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %h expected 0", {bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl});
        end
        vectors++;
        if ({bus.ex_rd, bus.mem_rd, bus.wb_rd, bus.ld_use_cnt, bus.id_stall} !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_tags_cnt_stall: got %h expected 0",
                     {bus.ex_rd, bus.mem_rd, bus.wb_rd, bus.ld_use_cnt, bus.id_stall});
        end
        rst = 1'b0;
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.id_stall} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %b expected 0000",
                     {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.id_stall});
        end
    endtask

    task automatic test_load_use();
        issue(LW, 5'd12, 5'd6, 5'd0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lu_lw_accept: got id_stall=%b expected 0", bus.id_stall);
        end
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.ex_rd, bus.ex_ctrl} !== {1'b1, 5'd12, LW[16:7]}) begin
            miscompares++;
            $display("[TB] FAIL lu_lw_in_ex: got %h expected %h", {bus.ex_valid, bus.ex_rd, bus.ex_ctrl},
                     {1'b1, 5'd12, LW[16:7]});
        end
        issue(ADD, 5'd13, 5'd12, 5'd5, 1'b1, 1'b1);
        #1;
        vectors++;
        if (bus.id_stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lu_stall: got id_stall=%b expected 1", bus.id_stall);
        end
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.ex_rd, bus.ex_ctrl} !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL lu_bubble: got %h expected 0", {bus.ex_valid, bus.ex_rd, bus.ex_ctrl});
        end
        vectors++;
        if ({bus.mem_valid, bus.mem_rd, bus.mem_ctrl, bus.ld_use_cnt} !== {1'b1, 5'd12, LW[6:2], 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL lu_lw_in_mem_cnt: got %h expected %h",
                     {bus.mem_valid, bus.mem_rd, bus.mem_ctrl, bus.ld_use_cnt}, {1'b1, 5'd12, LW[6:2], 16'd1});
        end
`ifndef CTRL_PIPE_FWD_EN
        vectors++;
        if (bus.id_stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lu_raw_hold: got id_stall=%b expected 1", bus.id_stall);
        end
        cycle();
`endif
        vectors++;
        if ({bus.id_stall, bus.ex_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL lu_release: got %b expected 00", {bus.id_stall, bus.ex_valid});
        end
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.ex_rd, bus.ex_ctrl, bus.ld_use_cnt} !== {1'b1, 5'd13, ADD[16:7], 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL lu_add_in_ex: got %h expected %h", {bus.ex_valid, bus.ex_rd, bus.ex_ctrl, bus.ld_use_cnt},
                     {1'b1, 5'd13, ADD[16:7], 16'd1});
        end
        idle();
        repeat (3) cycle();
    endtask

    task automatic test_raw();
        issue(ADD, 5'd12, 5'd11, 5'd12, 1'b1, 1'b1);
        cycle();
        issue(SUB, 5'd14, 5'd12, 5'd3, 1'b1, 1'b1);
        #1;
`ifdef CTRL_PIPE_FWD_EN
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL raw_fwd_no_stall: got id_stall=%b expected 0", bus.id_stall);
        end
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.ex_rd, bus.fwd_a, bus.fwd_b} !== {1'b1, 5'd14, 2'b01, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL raw_fwd_sel: got %h expected %h", {bus.ex_valid, bus.ex_rd, bus.fwd_a, bus.fwd_b},
                     {1'b1, 5'd14, 2'b01, 2'b00});
        end
`else
        vectors++;
        if (bus.id_stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL raw_stall1: got id_stall=%b expected 1", bus.id_stall);
        end
        cycle();
        vectors++;
        if ({bus.id_stall, bus.ex_valid, bus.mem_rd} !== {1'b1, 1'b0, 5'd12}) begin
            miscompares++;
            $display("[TB] FAIL raw_stall2: got %h expected %h", {bus.id_stall, bus.ex_valid, bus.mem_rd},
                     {1'b1, 1'b0, 5'd12});
        end
        cycle();
        vectors++;
        if ({bus.id_stall, bus.wb_valid, bus.wb_rd} !== {1'b0, 1'b1, 5'd12}) begin
            miscompares++;
            $display("[TB] FAIL raw_release: got %h expected %h", {bus.id_stall, bus.wb_valid, bus.wb_rd},
                     {1'b0, 1'b1, 5'd12});
        end
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.ex_rd, bus.ex_ctrl} !== {1'b1, 5'd14, SUB[16:7]}) begin
            miscompares++;
            $display("[TB] FAIL raw_sub_in_ex: got %h expected %h", {bus.ex_valid, bus.ex_rd, bus.ex_ctrl},
                     {1'b1, 5'd14, SUB[16:7]});
        end
`endif
        vectors++;
        if (bus.ld_use_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL raw_cnt_unchanged: got %h expected 0001", bus.ld_use_cnt);
        end
        idle();
        repeat (3) cycle();
    endtask

    task automatic test_rd_zero();
        issue(LW, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0);
        cycle();
        issue(ADD, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd0_no_hazard: got id_stall=%b expected 0", bus.id_stall);
        end
        cycle();
        issue(ADD, 5'd8, 5'd9, 5'd7, 1'b1, 1'b0);
        #1;
        vectors++;
        if ({bus.id_stall, bus.ex_valid, bus.ex_rd} !== {1'b0, 1'b1, 5'd7}) begin
            miscompares++;
            $display("[TB] FAIL unused_rs2_no_hazard: got %h expected %h", {bus.id_stall, bus.ex_valid, bus.ex_rd},
                     {1'b0, 1'b1, 5'd7});
        end
        cycle();
        idle();
        repeat (3) cycle();
        vectors++;
        if (bus.ld_use_cnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL rd0_cnt: got %h expected 0001", bus.ld_use_cnt);
        end
    endtask

    task automatic test_flush();
        issue(BNE, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);
        cycle();
        issue(ADD, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1);
        bus.flush = 1'b1;
        #1;
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_stall: got id_stall=%b expected 0", bus.id_stall);
        end
        cycle();
        bus.flush = 1'b0;
        idle();
        vectors++;
        if ({bus.ex_valid, bus.ex_rd, bus.ex_ctrl} !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL flush_bubble: got %h expected 0", {bus.ex_valid, bus.ex_rd, bus.ex_ctrl});
        end
        vectors++;
        if ({bus.mem_valid, bus.mem_ctrl} !== {1'b1, BNE[6:2]}) begin
            miscompares++;
            $display("[TB] FAIL flush_bne_in_mem: got %h expected %h", {bus.mem_valid, bus.mem_ctrl}, {1'b1, BNE[6:2]});
        end
        repeat (2) cycle();
        issue(LW, 5'd12, 5'd6, 5'd0, 1'b1, 1'b0);
        cycle();
        issue(ADD, 5'd13, 5'd12, 5'd5, 1'b1, 1'b1);
        bus.flush = 1'b1;
        #1;
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_over_hazard: got id_stall=%b expected 0", bus.id_stall);
        end
        cycle();
        bus.flush = 1'b0;
        idle();
        vectors++;
        if ({bus.ex_valid, bus.mem_valid, bus.mem_rd, bus.ld_use_cnt} !== {1'b0, 1'b1, 5'd12, 16'd1}) begin
            miscompares++;
            $display("[TB] FAIL flush_hazard_state: got %h expected %h",
                     {bus.ex_valid, bus.mem_valid, bus.mem_rd, bus.ld_use_cnt}, {1'b0, 1'b1, 5'd12, 16'd1});
        end
        repeat (3) cycle();
    endtask

    task automatic test_mem_stall();
        issue(ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        cycle();
        issue(SW, 5'd0, 5'd8, 5'd13, 1'b1, 1'b1);
        cycle();
        issue(ADD, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1);
        cycle();
        vectors++;
        if ({bus.wb_valid, bus.wb_rd, bus.mem_valid, bus.mem_ctrl} !== {1'b1, 5'd1, 1'b1, SW[6:2]}) begin
            miscompares++;
            $display("[TB] FAIL stall_setup: got %h expected %h", {bus.wb_valid, bus.wb_rd, bus.mem_valid, bus.mem_ctrl},
                     {1'b1, 5'd1, 1'b1, SW[6:2]});
        end
        issue(ADD, 5'd15, 5'd16, 5'd17, 1'b1, 1'b1);
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (bus.id_stall !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stall_id_stall cycle %0d: got %b expected 1", i, bus.id_stall);
            end
            cycle();
            vectors++;
            if ({bus.ex_valid, bus.ex_rd, bus.mem_valid, bus.mem_rd, bus.mem_ctrl} !==
                {1'b1, 5'd9, 1'b1, 5'd0, SW[6:2]}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h", i,
                         {bus.ex_valid, bus.ex_rd, bus.mem_valid, bus.mem_rd, bus.mem_ctrl},
                         {1'b1, 5'd9, 1'b1, 5'd0, SW[6:2]});
            end
            vectors++;
            if ({bus.wb_valid, bus.wb_ctrl, bus.wb_rd} !== 8'h0) begin
                miscompares++;
                $display("[TB] FAIL stall_wb_bubble cycle %0d: got %h expected 0", i,
                         {bus.wb_valid, bus.wb_ctrl, bus.wb_rd});
            end
        end
        bus.mem_stall = 1'b0;
        #1;
        vectors++;
        if (bus.id_stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got id_stall=%b expected 0", bus.id_stall);
        end
        cycle();
        vectors++;
        if ({bus.wb_valid, bus.wb_ctrl, bus.mem_valid, bus.mem_rd, bus.mem_ctrl, bus.ex_valid, bus.ex_rd} !==
            {1'b1, SW[1:0], 1'b1, 5'd9, ADD[6:2], 1'b1, 5'd15}) begin
            miscompares++;
            $display("[TB] FAIL stall_advance: got %h expected %h",
                     {bus.wb_valid, bus.wb_ctrl, bus.mem_valid, bus.mem_rd, bus.mem_ctrl, bus.ex_valid, bus.ex_rd},
                     {1'b1, SW[1:0], 1'b1, 5'd9, ADD[6:2], 1'b1, 5'd15});
        end
        idle();
        repeat (3) cycle();
    endtask

    task automatic test_saturation();
        logic [16:0] expCnt;
        int          expStalls;
`ifdef CTRL_PIPE_FWD_EN
        expStalls = 1;
`else
        expStalls = 2;
`endif
        force dut.ldUseCnt_q = 16'hFFFE;
        #2;
        release dut.ldUseCnt_q;
        expCnt = 17'h0FFFE;
        for (int k = 0; k < 3; k++) begin
            int n;
            issue(LW, 5'(20 + k), 5'd6, 5'd0, 1'b1, 1'b0);
            cycle();
            issue(ADD, 5'(24 + k), 5'(20 + k), 5'd5, 1'b1, 1'b1);
            #1;
            n = 0;
            while (bus.id_stall && n < 6) begin
                cycle();
                n++;
            end
            vectors++;
            if (n !== expStalls) begin
                miscompares++;
                $display("[TB] FAIL sat_stall_cycles pair %0d: got %0d expected %0d", k, n, expStalls);
            end
            expCnt = expCnt + 17'd1;
            if (expCnt > 17'h0FFFF) expCnt = 17'h0FFFF;
            vectors++;
            if (bus.ld_use_cnt !== expCnt[15:0]) begin
                miscompares++;
                $display("[TB] FAIL sat_cnt pair %0d: got %h expected %h", k, bus.ld_use_cnt, expCnt[15:0]);
            end
            cycle();
        end
        idle();
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid_stall();
        issue(ADD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle();
        issue(ADD, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle();
        issue(ADD, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle();
        issue(ADD, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        vectors++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL rst_stall_full: got %b expected 111", {bus.ex_valid, bus.mem_valid, bus.wb_valid});
        end
        bus.mem_stall = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.id_stall} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rst_stall_valids: got %b expected 0000",
                     {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.id_stall});
        end
        vectors++;
        if ({bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl, bus.ex_rd, bus.mem_rd, bus.wb_rd, bus.ld_use_cnt} !== 48'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_stall_ctrl: got %h expected 0",
                     {bus.ex_ctrl, bus.mem_ctrl, bus.wb_ctrl, bus.ex_rd, bus.mem_rd, bus.wb_rd, bus.ld_use_cnt});
        end
        rst = 1'b0;
        bus.mem_stall = 1'b0;
        idle();
        cycle();
        vectors++;
        if ({bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.id_stall} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rst_stall_after: got %b expected 0000",
                     {bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.id_stall});
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.mem_stall = 1'b0;
        bus.flush     = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_raw();
        test_rd_zero();
        test_flush();
        test_mem_stall();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
